vlan_tag_walker: RTL and testbench

//  Multi-cycle, parametrised VLAN resolver for stacked tags (802.1Q / 802.1ad QinQ).

---
 rtl/eth_parser_pkg.sv | 27 ++
 rtl/vlan_tpid_match.sv | 17 +
 rtl/vlan_tag_walker.sv | 163 ++++++++++++++++
 tb/tb_vlan_tag_walker.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_parser_pkg.sv
// Shared L2 parsing types: ethertype values, VLAN TCI layout and walker states.
package eth_parser_pkg;

    typedef logic [15:0] ethertype_t;

    localparam ethertype_t TPID_8021Q  = 16'h8100;
    localparam ethertype_t TPID_8021AD = 16'h88A8;
    localparam ethertype_t TPID_ALT    = 16'h9100;

    // Untagged Ethernet header length, bytes per VLAN tag, offset of the first ethertype/TPID field
    localparam int unsigned ETH_BASE_LEN = 14;
    localparam int unsigned TAG_BYTES    = 4;
    localparam int unsigned ETYPE_OFFSET = 12;

    typedef struct packed {
        logic [2:0]  pcp;
        logic        dei;
        logic [11:0] vid;
    } vlan_tci_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } walker_state_t;

endpackage

// File: rtl/vlan_tpid_match.sv
// Combinational TPID classifier; shared with the L2 filter.
module vlan_tpid_match
    import eth_parser_pkg::*;
(
    input  logic [15:0] ethertype,
    input  logic        alt_en,
    output logic        is_tpid
);

    // 0x8100 / 0x88A8 always tag; 0x9100 only when the legacy alternate TPID is enabled
    always_comb begin
        is_tpid = (ethertype_t'(ethertype) == TPID_8021Q)  ||
                  (ethertype_t'(ethertype) == TPID_8021AD) ||
                  (alt_en && (ethertype_t'(ethertype) == TPID_ALT));
    end

endmodule

// File: rtl/vlan_tag_walker.sv
// Multi-cycle stacked VLAN resolver: walks one tag per cycle from a latched L2 header.
module vlan_tag_walker
    import eth_parser_pkg::*;
#(
    parameter int unsigned MAX_TAGS    = 2,
    parameter int unsigned HDR_BYTES   = 22,
    parameter int unsigned ALT_TPID_EN = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [HDR_BYTES*8-1:0]           in_header,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(MAX_TAGS+1)-1:0]    tag_count,
    output logic [MAX_TAGS*16-1:0]           tci_flat,
    output logic [11:0]                      outer_vid,
    output logic [2:0]                       outer_pcp,
    output logic [15:0]                      resolved_ethertype,
    output logic [5:0]                       l2_header_len,
    output logic                             tag_overflow
);

    localparam int unsigned HDR_W = HDR_BYTES * 8;
    localparam int unsigned CNT_W = $clog2(MAX_TAGS + 1);
    localparam int unsigned OFF_W = $clog2(HDR_BYTES + 1);
    localparam int unsigned LEN_W = 6;

    // Reject configurations whose deepest read would fall outside the captured header
    if ((MAX_TAGS < 1) || (MAX_TAGS > 4)) begin : g_bad_max_tags
        $error("vlan_tag_walker: MAX_TAGS must be in 1..4");
    end
    if (HDR_BYTES < ETH_BASE_LEN + TAG_BYTES * MAX_TAGS) begin : g_bad_hdr_bytes
        $error("vlan_tag_walker: HDR_BYTES must be >= 14 + 4*MAX_TAGS");
    end

    walker_state_t state;
    walker_state_t state_next;

    logic [HDR_W-1:0]          hdr_q;
    logic [OFF_W-1:0]          off_q;
    logic [CNT_W-1:0]          cnt_q;
    vlan_tci_t [MAX_TAGS-1:0]  tci_q;
    ethertype_t                resolved_q;
    logic [LEN_W-1:0]          len_q;
    logic                      ovf_q;

    logic [31:0]               win_c;
    ethertype_t                field_c;
    logic [15:0]               tci_c;
    logic                      tpid_c;
    logic                      room_c;
    logic                      accept_c;
    logic                      tag_step_c;
    logic                      walk_end_c;
    logic                      ovf_hit_c;

    // Four-byte window at the current walk offset: field at off, TCI at off+2
    always_comb begin
        win_c   = 32'(hdr_q >> {off_q, 3'b000});
        field_c = win_c[15:0];
        tci_c   = win_c[31:16];
        room_c  = (cnt_q < CNT_W'(MAX_TAGS));
    end

    vlan_tpid_match u_tpid_match (
        .ethertype (field_c),
        .alt_en    (ALT_TPID_EN != 0),
        .is_tpid   (tpid_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        tag_step_c = 1'b0;
        walk_end_c = 1'b0;
        ovf_hit_c  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c   = 1'b1;
                    state_next = WALK;
                end
            end
            WALK: begin
                if (tpid_c && room_c) begin
                    tag_step_c = 1'b1;
                end else begin
                    walk_end_c = 1'b1;
                    ovf_hit_c  = tpid_c;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Header latch, walk offset/count, TCI slots and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q      <= '0;
            off_q      <= '0;
            cnt_q      <= '0;
            tci_q      <= '0;
            resolved_q <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (accept_c) begin
                hdr_q <= in_header;
                off_q <= OFF_W'(ETYPE_OFFSET);
                cnt_q <= '0;
                tci_q <= '0;
                ovf_q <= 1'b0;
            end
            if (tag_step_c) begin
                for (int i = 0; i < int'(MAX_TAGS); i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        tci_q[i] <= vlan_tci_t'(tci_c);
                    end
                end
                cnt_q <= cnt_q + CNT_W'(1);
                off_q <= off_q + OFF_W'(TAG_BYTES);
            end
            if (walk_end_c) begin
                resolved_q <= field_c;
                ovf_q      <= ovf_hit_c;
                len_q      <= LEN_W'(ETH_BASE_LEN + TAG_BYTES * 32'(cnt_q));
            end
        end
    end

    // Handshakes decode the state register; in_ready is held low throughout reset
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    assign tag_count          = cnt_q;
    assign tci_flat           = tci_q;
    assign outer_vid          = tci_q[0].vid;
    assign outer_pcp          = tci_q[0].pcp;
    assign resolved_ethertype = resolved_q;
    assign l2_header_len      = len_q;
    assign tag_overflow       = ovf_q;

endmodule

// File: tb/tb_vlan_tag_walker.sv
// Scoreboard bench for vlan_tag_walker (MAX_TAGS=2, HDR_BYTES=22), plus an ALT_TPID_EN=0 instance.
module tb_vlan_tag_walker;

    localparam int unsigned HB = 22;
    localparam int unsigned HW = HB * 8;

    typedef struct {
        logic [1:0]  cnt;
        logic [31:0] tci;
        logic [11:0] vid;
        logic [2:0]  pcp;
        logic [15:0] res;
        logic [5:0]  len;
        logic        ovf;
        int          lat;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [HW-1:0] in_header;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    tag_count;
    logic [31:0]   tci_flat;
    logic [11:0]   outer_vid;
    logic [2:0]    outer_pcp;
    logic [15:0]   resolved_ethertype;
    logic [5:0]    l2_header_len;
    logic          tag_overflow;

    logic          b_in_valid;
    logic          b_in_ready;
    logic [HW-1:0] b_in_header;
    logic          b_out_valid;
    logic          b_out_ready;
    logic [1:0]    b_tag_count;
    logic [31:0]   b_tci_flat;
    logic [11:0]   b_outer_vid;
    logic [2:0]    b_outer_pcp;
    logic [15:0]   b_resolved;
    logic [5:0]    b_len;
    logic          b_ovf;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    logic seen   = 1'b0;

    vlan_tag_walker #(.MAX_TAGS(2), .HDR_BYTES(HB), .ALT_TPID_EN(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_header(in_header),
        .out_valid(out_valid), .out_ready(out_ready),
        .tag_count(tag_count), .tci_flat(tci_flat),
        .outer_vid(outer_vid), .outer_pcp(outer_pcp),
        .resolved_ethertype(resolved_ethertype), .l2_header_len(l2_header_len),
        .tag_overflow(tag_overflow)
    );

    vlan_tag_walker #(.MAX_TAGS(2), .HDR_BYTES(HB), .ALT_TPID_EN(0)) dut_noalt (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_header(b_in_header),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .tag_count(b_tag_count), .tci_flat(b_tci_flat),
        .outer_vid(b_outer_vid), .outer_pcp(b_outer_pcp),
        .resolved_ethertype(b_resolved), .l2_header_len(b_len),
        .tag_overflow(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [HW-1:0] mk(input logic [15:0] f0, input logic [15:0] f1,
                                         input logic [15:0] f2, input logic [15:0] f3,
                                         input logic [15:0] f4);
        logic [HW-1:0] h;
        h          = '0;
        h[95:0]    = 96'h0011_2233_4455_6677_8899_AABB;
        h[96 +: 16]  = f0;
        h[112 +: 16] = f1;
        h[128 +: 16] = f2;
        h[144 +: 16] = f3;
        h[160 +: 16] = f4;
        return h;
    endfunction

    function automatic exp_t mx(input logic [1:0] cnt, input logic [31:0] tci,
                                input logic [11:0] vid, input logic [2:0] pcp,
                                input logic [15:0] res, input logic [5:0] len,
                                input logic ovf, input int lat);
        exp_t e;
        e.cnt = cnt; e.tci = tci; e.vid = vid; e.pcp = pcp;
        e.res = res; e.len = len; e.ovf = ovf; e.lat = lat;
        return e;
    endfunction

    // Monitor: record accept cycles, compare every cycle of a presented result, pop on handshake
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        seen = 1'b1;
                        if (acc_q.size() > 0) chk("latency", 32'(cyc - acc_q.pop_front()), 32'(e.lat));
                        else fail_now("latency_no_accept");
                    end
                    chk("tag_count", 32'(tag_count), 32'(e.cnt));
                    chk("tci_flat", tci_flat, e.tci);
                    chk("outer_vid", 32'(outer_vid), 32'(e.vid));
                    chk("outer_pcp", 32'(outer_pcp), 32'(e.pcp));
                    chk("resolved", 32'(resolved_ethertype), 32'(e.res));
                    chk("l2_len", 32'(l2_header_len), 32'(e.len));
                    chk("overflow", 32'(tag_overflow), 32'(e.ovf));
                    chk("in_ready_in_done", 32'(in_ready), 32'(0));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [HW-1:0] h, input exp_t e);
        int t;
        t = 0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_header = h;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_header = HW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    task automatic wait_out_valid(output logic ok);
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = out_valid;
        if (!ok) fail_now("out_valid_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic ok;
        int   t;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_header   = '0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_header = '0;
        b_out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_tag_count", 32'(tag_count), 32'(0));
        chk("rst_tci_flat", tci_flat, 32'h0);
        chk("rst_resolved", 32'(resolved_ethertype), 32'(0));
        chk("rst_len", 32'(l2_header_len), 32'(0));
        chk("rst_overflow", 32'(tag_overflow), 32'(0));
        chk("rst_b_in_ready", 32'(b_in_ready), 32'(0));
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'(1));

        // Untagged, single tag, QinQ, alternate TPID, overflow, same TPID twice
        send(mk(16'h0800, 16'h8100, 16'h0000, 16'h0000, 16'h0000),
             mx(2'd0, 32'h0000_0000, 12'h000, 3'd0, 16'h0800, 6'd14, 1'b0, 1));
        send(mk(16'h8100, 16'hA005, 16'h86DD, 16'h0000, 16'h0000),
             mx(2'd1, 32'h0000_A005, 12'h005, 3'd5, 16'h86DD, 6'd18, 1'b0, 2));
        send(mk(16'h88A8, 16'h0064, 16'h8100, 16'h00C8, 16'h0800),
             mx(2'd2, 32'h00C8_0064, 12'h064, 3'd0, 16'h0800, 6'd22, 1'b0, 3));
        send(mk(16'h9100, 16'h2003, 16'h0800, 16'h0000, 16'h0000),
             mx(2'd1, 32'h0000_2003, 12'h003, 3'd1, 16'h0800, 6'd18, 1'b0, 2));
        send(mk(16'h8100, 16'h1111, 16'h8100, 16'h2222, 16'h8100),
             mx(2'd2, 32'h2222_1111, 12'h111, 3'd0, 16'h8100, 6'd22, 1'b1, 3));
        send(mk(16'h88A8, 16'hF001, 16'h88A8, 16'h0002, 16'h86DD),
             mx(2'd2, 32'h0002_F001, 12'h001, 3'd7, 16'h86DD, 6'd22, 1'b0, 3));
        drain();

        // Backpressure in DONE with a second header waiting
        out_ready = 1'b0;
        send(mk(16'h8100, 16'hE00A, 16'h0806, 16'h0000, 16'h0000),
             mx(2'd1, 32'h0000_E00A, 12'h00A, 3'd7, 16'h0806, 6'd18, 1'b0, 2));
        fork
            send(mk(16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0000),
                 mx(2'd0, 32'h0000_0000, 12'h000, 3'd0, 16'h0800, 6'd14, 1'b0, 1));
            begin
                wait_out_valid(ok);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-walk on a QinQ header drops it
        send(mk(16'h88A8, 16'h0064, 16'h8100, 16'h00C8, 16'h0800),
             mx(2'd2, 32'h00C8_0064, 12'h064, 3'd0, 16'h0800, 6'd22, 1'b0, 3));
        @(posedge clk); #1;
        exp_q.delete();
        acc_q.delete();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(0));
        chk("midrst_tag_count", 32'(tag_count), 32'(0));
        chk("midrst_tci_flat", tci_flat, 32'h0);
        chk("midrst_resolved", 32'(resolved_ethertype), 32'(0));
        chk("midrst_len", 32'(l2_header_len), 32'(0));
        chk("midrst_overflow", 32'(tag_overflow), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(mk(16'h0800, 16'h8100, 16'h0000, 16'h0000, 16'h0000),
             mx(2'd0, 32'h0000_0000, 12'h000, 3'd0, 16'h0800, 6'd14, 1'b0, 1));
        drain();

        // ALT_TPID_EN=0: 0x9100 is an ethertype
        @(posedge clk); #1;
        b_in_valid  = 1'b1;
        b_in_header = mk(16'h9100, 16'h2003, 16'h0800, 16'h0000, 16'h0000);
        t = 0;
        @(negedge clk);
        while (!b_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!b_in_ready) fail_now("noalt_accept_timeout");
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!b_out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!b_out_valid) begin
            fail_now("noalt_out_valid_timeout");
        end else begin
            chk("noalt_tag_count", 32'(b_tag_count), 32'(0));
            chk("noalt_resolved", 32'(b_resolved), 32'h9100);
            chk("noalt_len", 32'(b_len), 32'(14));
            chk("noalt_overflow", 32'(b_ovf), 32'(0));
            chk("noalt_tci_flat", b_tci_flat, 32'h0);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
